// File: rtl/mips32_pipe_fwd_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips32_pipe_fwd_if                                              |
// | Purpose  : Memory-side bus of the mips32_pipe_fwd core. The instruction     |
// |            port and the data port are both combinational-read: read data   |
// |            is valid in the same cycle as the address.                      |
// | Signals  : imem_addr/imem_rdata   - fetch word address / instruction       |
// |            dmem_addr/dmem_re/we   - data word address, load, store strobe  |
// |            dmem_wdata/dmem_rdata  - store data / load data                 |
// | Modports : master (core side), slave (memory side)                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface mips32_pipe_fwd_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [ADDR_W-1:0] dmem_addr;
  logic              dmem_re;
  logic              dmem_we;
  logic [XLEN-1:0]   dmem_wdata;
  logic [XLEN-1:0]   dmem_rdata;

  modport master (
    output imem_addr, input imem_rdata,
    output dmem_addr, output dmem_re, output dmem_we, output dmem_wdata,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr, output imem_rdata,
    input  dmem_addr, input dmem_re, input dmem_we, input dmem_wdata,
    output dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mips32_pipe_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips32_pipe_fwd                                                 |
// | Purpose  : Five-stage (IF/ID/EX/MEM/WB) MIPS32-subset integer core with     |
// |            operand forwarding, load-use interlock, taken-branch flush in   |
// |            EX and a clean halt.                                            |
// | Ports    : clk, rst        - clock, synchronous active-high reset          |
// |            bus (master)    - instruction and data memory ports            |
// |            halted          - sticky, set when HLT leaves WB                |
// |            retire_valid    - a valid instruction is in WB                  |
// |            retire_pc       - word address of that instruction             |
// | Note     : bus must be instantiated with the same XLEN/ADDR_W as the core. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mips32_pipe_fwd #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 10,
  parameter int FWD_EN = 1
) (
  input  wire                clk,
  input  wire                rst,
  mips32_pipe_fwd_if.master  bus,
  output logic               halted,
  output logic               retire_valid,
  output logic [ADDR_W-1:0]  retire_pc
);
  localparam logic [5:0] OP_ADD   = 6'h00, OP_SUB  = 6'h01, OP_AND  = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03, OP_SLT  = 6'h04, OP_MUL  = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08, OP_SW   = 6'h09, OP_ADDI = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B, OP_SLTI = 6'h0C, OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E, OP_HLT  = 6'h3F;

  // Fetch / IF-ID
  logic [ADDR_W-1:0] pc, id_pc;
  logic              id_v;
  logic [31:0]       id_ir;
  // ID-EX
  logic              ex_v, ex_wr, ex_lw;
  logic [ADDR_W-1:0] ex_pc;
  logic [5:0]        ex_op;
  logic [4:0]        ex_rs, ex_rt, ex_dest;
  logic [15:0]       ex_imm;
  logic [XLEN-1:0]   ex_a, ex_b;
  // EX-MEM
  logic              mem_v, mem_wr, mem_lw, mem_sw, mem_hlt;
  logic [ADDR_W-1:0] mem_pc;
  logic [4:0]        mem_dest;
  logic [XLEN-1:0]   mem_alu, mem_sd;
  // MEM-WB
  logic              wb_v, wb_wr, wb_hlt;
  logic [ADDR_W-1:0] wb_pc;
  logic [4:0]        wb_dest;
  logic [XLEN-1:0]   wb_res;

  logic [XLEN-1:0]   rf [32];

  // ---------------------------------------------------------------- decode
  logic [5:0]      d_op;
  logic [4:0]      d_rs, d_rt, d_rd, d_dest;
  logic            d_rr, d_rm, d_lw, d_sw, d_br, d_hlt, d_use_rs, d_use_rt, d_wr;
  logic [XLEN-1:0] d_a, d_b;

  always_comb begin
    d_rs  = id_ir[25:21];
    d_rt  = id_ir[20:16];
    d_rd  = id_ir[15:11];
    d_op  = id_ir[31:26];
    d_rr  = 1'b0;
    d_rm  = 1'b0;
    d_lw  = 1'b0;
    d_sw  = 1'b0;
    d_br  = 1'b0;
    d_hlt = 1'b0;
    case (id_ir[31:26])
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: d_rr = 1'b1;
      OP_ADDI, OP_SUBI, OP_SLTI:                     d_rm = 1'b1;
      OP_LW:                                         d_lw = 1'b1;
      OP_SW:                                         d_sw = 1'b1;
      OP_BNEQZ, OP_BEQZ:                             d_br = 1'b1;
      default: begin
        // Unknown opcodes are normalised to HLT so later stages see one code.
        d_hlt = 1'b1;
        d_op  = OP_HLT;
      end
    endcase
    d_use_rs = d_rr | d_rm | d_lw | d_sw | d_br;
    d_use_rt = d_rr | d_sw;
    d_dest   = d_rr ? d_rd : ((d_rm | d_lw) ? d_rt : 5'd0);
    d_wr     = (d_dest != 5'd0);
    // Write-through: a WB write is seen by the ID read in the same cycle.
    d_a = (wb_v && wb_wr && wb_dest == d_rs) ? wb_res : rf[d_rs];
    d_b = (wb_v && wb_wr && wb_dest == d_rt) ? wb_res : rf[d_rt];
  end

  // ---------------------------------------------------------------- hazards
  logic hit_ex, hit_mem, raw_stall, fwd_on;

  assign hit_ex  = ex_v && ex_wr &&
                   ((d_use_rs && ex_dest == d_rs) || (d_use_rt && ex_dest == d_rt));
  assign hit_mem = mem_v && mem_wr &&
                   ((d_use_rs && mem_dest == d_rs) || (d_use_rt && mem_dest == d_rt));

  if (FWD_EN != 0) begin : g_fwd
    // Only a load one stage ahead cannot be bypassed in time.
    assign raw_stall = id_v && hit_ex && ex_lw;
    assign fwd_on    = 1'b1;
  end else begin : g_stall
    assign raw_stall = id_v && (hit_ex || hit_mem);
    assign fwd_on    = 1'b0;
  end

  // ---------------------------------------------------------------- execute
  logic [XLEN-1:0]   op_a, op_b, imm_x, alu;
  logic [ADDR_W-1:0] target;
  logic              taken, flush, stall, hlt_inflight;

  always_comb begin
    op_a = ex_a;
    if (fwd_on && mem_v && mem_wr && !mem_lw && mem_dest == ex_rs) op_a = mem_alu;
    else if (fwd_on && wb_v && wb_wr && wb_dest == ex_rs)          op_a = wb_res;
    op_b = ex_b;
    if (fwd_on && mem_v && mem_wr && !mem_lw && mem_dest == ex_rt) op_b = mem_alu;
    else if (fwd_on && wb_v && wb_wr && wb_dest == ex_rt)          op_b = wb_res;

    imm_x = XLEN'(signed'(ex_imm));
    case (ex_op)
      OP_ADD:                 alu = op_a + op_b;
      OP_SUB:                 alu = op_a - op_b;
      OP_AND:                 alu = op_a & op_b;
      OP_OR:                  alu = op_a | op_b;
      OP_SLT:                 alu = XLEN'($signed(op_a) < $signed(op_b));
      OP_MUL:                 alu = op_a * op_b;
      OP_LW, OP_SW, OP_ADDI:  alu = op_a + imm_x;
      OP_SUBI:                alu = op_a - imm_x;
      OP_SLTI:                alu = XLEN'($signed(op_a) < $signed(imm_x));
      default:                alu = '0;
    endcase

    taken  = ex_v && ((ex_op == OP_BEQZ  && op_a == '0) ||
                      (ex_op == OP_BNEQZ && op_a != '0));
    target = ex_pc + ADDR_W'(1) + ADDR_W'(signed'(ex_imm));
  end

  assign flush = taken;
  assign stall = raw_stall && !flush;
  // Fetch stays frozen from the moment a HLT sits in ID until the core halts.
  assign hlt_inflight = (id_v && d_hlt) || (ex_v && ex_op == OP_HLT) ||
                        (mem_v && mem_hlt) || (wb_v && wb_hlt);

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;  halted <= 1'b0;
      id_v <= 1'b0; id_pc <= '0; id_ir <= '0;
      ex_v <= 1'b0; ex_wr <= 1'b0; ex_lw <= 1'b0; ex_pc <= '0; ex_op <= '0;
      ex_rs <= '0; ex_rt <= '0; ex_dest <= '0; ex_imm <= '0; ex_a <= '0; ex_b <= '0;
      mem_v <= 1'b0; mem_wr <= 1'b0; mem_lw <= 1'b0; mem_sw <= 1'b0; mem_hlt <= 1'b0;
      mem_pc <= '0; mem_dest <= '0; mem_alu <= '0; mem_sd <= '0;
      wb_v <= 1'b0; wb_wr <= 1'b0; wb_hlt <= 1'b0; wb_pc <= '0; wb_dest <= '0; wb_res <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halted) begin
      if (flush)                        pc <= target;
      else if (!stall && !hlt_inflight) pc <= pc + ADDR_W'(1);

      if (flush || (!stall && hlt_inflight)) begin
        id_v <= 1'b0;
      end else if (!stall) begin
        id_v  <= 1'b1;
        id_pc <= pc;
        id_ir <= bus.imem_rdata;
      end

      ex_v    <= id_v && !flush && !stall;
      ex_pc   <= id_pc;
      ex_op   <= d_op;
      ex_rs   <= d_rs;
      ex_rt   <= d_rt;
      ex_dest <= d_dest;
      ex_wr   <= d_wr;
      ex_lw   <= d_lw;
      ex_imm  <= id_ir[15:0];
      ex_a    <= d_a;
      ex_b    <= d_b;

      mem_v    <= ex_v;
      mem_pc   <= ex_pc;
      mem_dest <= ex_dest;
      mem_wr   <= ex_wr;
      mem_lw   <= (ex_op == OP_LW);
      mem_sw   <= (ex_op == OP_SW);
      mem_hlt  <= (ex_op == OP_HLT);
      mem_alu  <= alu;
      mem_sd   <= op_b;

      wb_v    <= mem_v;
      wb_pc   <= mem_pc;
      wb_dest <= mem_dest;
      wb_wr   <= mem_wr;
      wb_hlt  <= mem_hlt;
      wb_res  <= mem_lw ? bus.dmem_rdata : mem_alu;

      if (wb_v && wb_wr)  rf[wb_dest] <= wb_res;
      if (wb_v && wb_hlt) halted <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = mem_alu[ADDR_W-1:0];
  assign bus.dmem_re    = mem_v && mem_lw;
  assign bus.dmem_we    = mem_v && mem_sw;
  assign bus.dmem_wdata = mem_sd;
  assign retire_valid   = wb_v;
  assign retire_pc      = wb_pc;
endmodule
`default_nettype wire

// File: tb/tb_mips32_pipe_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mips32_pipe_fwd                                              |
// | Purpose  : Scoreboard bench for mips32_pipe_fwd. Three cores are built:    |
// |            0 = XLEN 32 forwarding, 1 = XLEN 32 stall-only, 2 = XLEN 16.    |
// |            One core runs at a time; the others are held in reset.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mips32_pipe_fwd;
  localparam int ADDR_W = 10;
  localparam int NI     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]     rst = '1;
  logic              dload = 1'b0;
  logic [31:0]       imem [NI][64];
  logic [31:0]       dinit [64];

  wire [NI-1:0]      w_rv, w_we, w_re, w_hlt;
  wire [ADDR_W-1:0]  w_rpc [NI];
  wire [ADDR_W-1:0]  w_iaddr [NI];
  wire [ADDR_W-1:0]  w_daddr [NI];
  wire [31:0]        w_wdata [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int XW = (g == 2) ? 16 : 32;
    localparam int FW = (g == 1) ? 0 : 1;
    logic [XW-1:0] dmem [64];

    mips32_pipe_fwd_if #(.XLEN(XW), .ADDR_W(ADDR_W)) bus ();

    mips32_pipe_fwd #(.XLEN(XW), .ADDR_W(ADDR_W), .FWD_EN(FW)) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .bus          (bus),
      .halted       (w_hlt[g]),
      .retire_valid (w_rv[g]),
      .retire_pc    (w_rpc[g])
    );

    assign bus.imem_rdata = imem[g][bus.imem_addr[5:0]];
    assign bus.dmem_rdata = dmem[bus.dmem_addr[5:0]];
    always @(posedge clk) begin
      if (dload) for (int i = 0; i < 64; i++) dmem[i] <= XW'(dinit[i]);
      else if (bus.dmem_we) dmem[bus.dmem_addr[5:0]] <= bus.dmem_wdata;
    end
    assign w_we[g]    = bus.dmem_we;
    assign w_re[g]    = bus.dmem_re;
    assign w_daddr[g] = bus.dmem_addr;
    assign w_iaddr[g] = bus.imem_addr;
    assign w_wdata[g] = 32'(bus.dmem_wdata);
  end

  // ---------------------------------------------------------------- scoreboard
  int n_chk = 0, n_fail = 0;
  int sel = 0;
  int cyc = 0;   // edges since reset release of the selected core
  int exp_pc[$], exp_rc[$], exp_sa[$], exp_sd[$], exp_sc[$];

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst[sel]) cyc = 0;
    else          cyc++;
  end

  // Monitor: pops an expectation whenever the core retires or stores.
  initial forever begin
    @(negedge clk);
    if (!rst[sel]) begin
      if (w_rv[sel]) begin
        if (exp_pc.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL retire_extra: pc %0d retired at edge %0d, none expected", w_rpc[sel], cyc);
        end else begin
          check("retire_pc", w_rpc[sel], exp_pc.pop_front());
          check("retire_edge", cyc, exp_rc.pop_front());
        end
      end
      if (w_we[sel]) begin
        if (exp_sa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL store_extra: addr %0d data 0x%0h at edge %0d, none expected",
                   w_daddr[sel], w_wdata[sel], cyc);
        end else begin
          check("store_addr", w_daddr[sel], exp_sa.pop_front());
          check("store_data", w_wdata[sel], exp_sd.pop_front());
          check("store_edge", cyc, exp_sc.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  function automatic logic [31:0] f_rr(input logic [5:0] op, input int rd, input int rs, input int rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction
  function automatic logic [31:0] f_ri(input logic [5:0] op, input int rt, input int rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  localparam logic [31:0] HLT = {6'h3F, 26'd0};

  task automatic clear_imem(input int inst);
    for (int i = 0; i < 64; i++) imem[inst][i] = 32'd0;
  endtask

  task automatic exp_ret(input int pc, input int edge_no);
    exp_pc.push_back(pc);
    exp_rc.push_back(edge_no);
  endtask

  task automatic exp_st(input int addr, input int data, input int edge_no);
    exp_sa.push_back(addr);
    exp_sd.push_back(data);
    exp_sc.push_back(edge_no);
  endtask

  // Holds every core in reset, reloads data memory, then releases one core
  // at a falling edge so the next rising edge is release edge 1.
  task automatic start(input int inst);
    rst = '1;
    sel = inst;
    dload = 1'b1;
    @(negedge clk);
    dload = 1'b0;
    repeat (2) @(negedge clk);
    rst[inst] = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_imem_addr"},    w_iaddr[sel], 0);
    check({tag, "_dmem_we"},      w_we[sel], 0);
    check({tag, "_dmem_re"},      w_re[sel], 0);
    check({tag, "_retire_valid"}, w_rv[sel], 0);
    check({tag, "_retire_pc"},    w_rpc[sel], 0);
    check({tag, "_dmem_addr"},    w_daddr[sel], 0);
    check({tag, "_halted"},       w_hlt[sel], 0);
  endtask

  task automatic wait_halt(input string tag, input int exp_edge);
    int got = -1;
    for (int i = 0; i < 100 && got < 0; i++) begin
      @(negedge clk);
      if (w_hlt[sel]) got = cyc;
    end
    check({tag, "_halt_edge"}, got, exp_edge);
    repeat (4) @(negedge clk);
    check({tag, "_retires_left"}, exp_pc.size(), 0);
    check({tag, "_stores_left"}, exp_sa.size(), 0);
  endtask

  task automatic load_use_prog();
    clear_imem(0);
    imem[0][0] = f_ri(6'h0A, 1, 0, 5);    // ADDI R1,R0,5
    imem[0][1] = f_ri(6'h08, 2, 1, 0);    // LW   R2,0(R1)
    imem[0][2] = f_rr(6'h00, 3, 2, 2);    // ADD  R3,R2,R2
    imem[0][3] = f_ri(6'h09, 3, 1, 1);    // SW   R3,1(R1)
    imem[0][4] = HLT;
  endtask

  task automatic load_use_expect();
    exp_ret(0, 4); exp_ret(1, 5); exp_ret(2, 7); exp_ret(3, 8); exp_ret(4, 9);
    exp_st(6, 14, 7);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int k = 0; k < NI; k++) clear_imem(k);
    for (int i = 0; i < 64; i++) dinit[i] = 32'd0;
    dinit[5] = 32'd7;

    // Reset values
    sel = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // Back-to-back dependency with forwarding
    imem[0][0] = f_ri(6'h0A, 1, 0, 10);
    imem[0][1] = f_ri(6'h0A, 2, 0, 20);
    imem[0][2] = f_rr(6'h00, 3, 1, 2);
    imem[0][3] = HLT;
    start(0);
    exp_ret(0, 4); exp_ret(1, 5); exp_ret(2, 6); exp_ret(3, 7);
    wait_halt("fwd", 8);
    check("fwd_r1", g_dut[0].u_dut.rf[1], 10);
    check("fwd_r2", g_dut[0].u_dut.rf[2], 20);
    check("fwd_r3", g_dut[0].u_dut.rf[3], 30);

    // Same program, stall-only core: two stall cycles
    imem[1][0] = f_ri(6'h0A, 1, 0, 10);
    imem[1][1] = f_ri(6'h0A, 2, 0, 20);
    imem[1][2] = f_rr(6'h00, 3, 1, 2);
    imem[1][3] = HLT;
    start(1);
    exp_ret(0, 4); exp_ret(1, 5); exp_ret(2, 8); exp_ret(3, 9);
    wait_halt("nofwd", 10);
    check("nofwd_r3", g_dut[1].u_dut.rf[3], 30);

    // Load-use interlock
    load_use_prog();
    start(0);
    load_use_expect();
    wait_halt("lduse", 10);
    check("lduse_r2", g_dut[0].u_dut.rf[2], 7);
    check("lduse_r3", g_dut[0].u_dut.rf[3], 14);
    check("lduse_dmem6", g_dut[0].dmem[6], 14);

    // Taken branch squashes two younger slots
    clear_imem(0);
    imem[0][0] = f_ri(6'h0E, 0, 0, 2);    // BEQZ R0,+2
    imem[0][1] = f_ri(6'h0A, 4, 0, 1);    // ADDI R4,R0,1
    imem[0][2] = f_ri(6'h09, 0, 0, 0);    // SW   R0,0(R0)
    imem[0][3] = f_ri(6'h0A, 5, 0, 3);    // ADDI R5,R0,3
    imem[0][4] = HLT;
    start(0);
    exp_ret(0, 4); exp_ret(3, 7); exp_ret(4, 8);
    wait_halt("branch", 9);
    check("branch_r4", g_dut[0].u_dut.rf[4], 0);
    check("branch_r5", g_dut[0].u_dut.rf[5], 3);

    // 16-bit datapath arithmetic
    imem[2][0] = f_ri(6'h0A, 1, 0, -1);   // ADDI R1,R0,-1
    imem[2][1] = f_ri(6'h0A, 2, 1, 1);    // ADDI R2,R1,1
    imem[2][2] = f_ri(6'h0C, 3, 1, 0);    // SLTI R3,R1,0
    imem[2][3] = f_rr(6'h05, 4, 1, 1);    // MUL  R4,R1,R1
    imem[2][4] = HLT;
    start(2);
    exp_ret(0, 4); exp_ret(1, 5); exp_ret(2, 6); exp_ret(3, 7); exp_ret(4, 8);
    wait_halt("x16", 9);
    check("x16_r1", g_dut[2].u_dut.rf[1], 'hFFFF);
    check("x16_r2", g_dut[2].u_dut.rf[2], 0);
    check("x16_r3", g_dut[2].u_dut.rf[3], 1);
    check("x16_r4", g_dut[2].u_dut.rf[4], 1);

    // Reset during the load-use stall, then a full re-run
    load_use_prog();
    start(0);
    for (int i = 0; i < 20 && cyc != 3; i++) @(negedge clk);
    check("midrun_stall_pc", w_iaddr[0], 3);
    rst[0] = 1'b1;
    @(negedge clk);
    check_reset_vals("midrun");
    load_use_expect();
    rst[0] = 1'b0;
    wait_halt("rerun", 10);
    check("rerun_r3", g_dut[0].u_dut.rf[3], 14);
    check("rerun_dmem6", g_dut[0].dmem[6], 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, %0d checks done", n_chk);
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
